// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter: FSM state encoding
// and requester identifiers.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage : ram_arb_pkg

// File: rtl/ram_bank.sv
// Single-port synchronous RAM: one access per enabled clock, registered read data,
// storage is never reset.
module ram_bank #(
    parameter int WORD_W = 1,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    // Read data holds its last value between reads.
    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule : ram_bank

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one ram_bank between two valid/ready requesters.
// Optional feature: define RAM_ARBITER_PARITY_EN for even parity per stored word.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_W = 1,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_perr,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_perr
);

`ifdef RAM_ARBITER_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              winner;
    logic              grant0, grant1;
    logic              ramEn, ramWe;
    logic [WORD_W-1:0] ramWdata, ramRdata;
    logic [DATA_W-1:0] rdData;
    logic              perrRaw;
    logic              respRead;

    // Ties go to the requester that did not win last time.
    always_comb begin
        winner = REQ0;
        if (req0_valid && req1_valid) begin
            winner = ~last_grant_q;
        end else if (req1_valid) begin
            winner = REQ1;
        end
    end

    assign req0_ready = reset_n & (state_q == IDLE) & req0_valid & (winner == REQ0);
    assign req1_ready = reset_n & (state_q == IDLE) & req1_valid & (winner == REQ1);
    assign grant0     = req0_valid & req0_ready;
    assign grant1     = req1_valid & req1_ready;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        case (state_q)
            IDLE: begin
                if (grant1) begin
                    owner_d      = REQ1;
                    write_d      = req1_write;
                    addr_d       = req1_addr;
                    wdata_d      = req1_wdata;
                    last_grant_d = REQ1;
                    state_d      = ACCESS;
                end else if (grant0) begin
                    owner_d      = REQ0;
                    write_d      = req0_write;
                    addr_d       = req0_addr;
                    wdata_d      = req0_wdata;
                    last_grant_d = REQ0;
                    state_d      = ACCESS;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= REQ1;
            owner_q      <= REQ0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // The RAM only sees the registered op, so a reset before the ACCESS edge drops it cleanly.
    assign ramEn = (state_q == ACCESS);
    assign ramWe = ramEn & write_q;

`ifdef RAM_ARBITER_PARITY_EN
    assign ramWdata = {^wdata_q, wdata_q};
    assign rdData   = ramRdata[DATA_W-1:0];
    assign perrRaw  = ^ramRdata;
`else
    assign ramWdata = wdata_q;
    assign rdData   = ramRdata;
    assign perrRaw  = 1'b0;
`endif

    ram_bank #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clock (clock),
        .en    (ramEn),
        .we    (ramWe),
        .addr  (addr_q),
        .wdata (ramWdata),
        .rdata (ramRdata)
    );

    assign rsp0_valid = (state_q == RESP) & (owner_q == REQ0);
    assign rsp1_valid = (state_q == RESP) & (owner_q == REQ1);
    assign respRead   = ~write_q;

    assign rsp0_rdata = (rsp0_valid & respRead) ? rdData : '0;
    assign rsp1_rdata = (rsp1_valid & respRead) ? rdData : '0;
    assign rsp0_perr  = rsp0_valid & respRead & perrRaw;
    assign rsp1_perr  = rsp1_valid & respRead & perrRaw;

endmodule : ram_arbiter

// File: tb/tb_ram_arbiter.sv
// Directed, table-driven bench for ram_arbiter: one 3-cycle op per table record,
// plus hand sequences for reset mid-access and (with RAM_ARBITER_PARITY_EN) parity.
module tb_ram_arbiter;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       req0_valid, req0_ready, req0_write;
    logic [3:0] req0_addr;
    logic       req0_wdata;
    logic       rsp0_valid, rsp0_perr;
    logic       rsp0_rdata;
    logic       req1_valid, req1_ready, req1_write;
    logic [3:0] req1_addr;
    logic       req1_wdata;
    logic       rsp1_valid, rsp1_perr;
    logic       rsp1_rdata;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic       v0;
        logic       w0;
        logic [3:0] a0;
        logic       d0;
        logic       v1;
        logic       w1;
        logic [3:0] a1;
        logic       d1;
        logic       expOwner;
        logic       expRdata;
        logic       expPerr;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    always #5 clock = ~clock;

    ram_arbiter #(.DATA_W(1), .ADDR_W(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_write (req0_write),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .rsp0_perr  (rsp0_perr),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_write (req1_write),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .rsp1_perr  (rsp1_perr)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ready0"}, 32'(req0_ready), 32'd0);
        checkOutput({tag, "_ready1"}, 32'(req1_ready), 32'd0);
        checkOutput({tag, "_rsp0_valid"}, 32'(rsp0_valid), 32'd0);
        checkOutput({tag, "_rsp1_valid"}, 32'(rsp1_valid), 32'd0);
        checkOutput({tag, "_rsp0_rdata"}, 32'(rsp0_rdata), 32'd0);
        checkOutput({tag, "_rsp1_rdata"}, 32'(rsp1_rdata), 32'd0);
        checkOutput({tag, "_rsp0_perr"}, 32'(rsp0_perr), 32'd0);
        checkOutput({tag, "_rsp1_perr"}, 32'(rsp1_perr), 32'd0);
    endtask

    // Called just after a rising edge with the FSM in IDLE; returns just after the
    // rising edge that brings it back to IDLE.
    task automatic applyStimulus(input vec_t v, input int idx);
        string tag;
        logic  rspOwn, rspOther, rdOwn, perrOwn;
        tag = $sformatf("v%0d", idx);
        req0_valid = v.v0; req0_write = v.w0; req0_addr = v.a0; req0_wdata = v.d0;
        req1_valid = v.v1; req1_write = v.w1; req1_addr = v.a1; req1_wdata = v.d1;
        @(negedge clock);
        checkOutput({tag, "_idle_rsp0"}, 32'(rsp0_valid), 32'd0);
        checkOutput({tag, "_idle_rsp1"}, 32'(rsp1_valid), 32'd0);
        checkOutput({tag, "_ready0"}, 32'(req0_ready), 32'(v.expOwner == 1'b0));
        checkOutput({tag, "_ready1"}, 32'(req1_ready), 32'(v.expOwner == 1'b1));
        @(posedge clock); #1;
        if (v.expOwner) req1_valid = 1'b0;
        else            req0_valid = 1'b0;
        @(negedge clock);
        checkOutput({tag, "_acc_ready0"}, 32'(req0_ready), 32'd0);
        checkOutput({tag, "_acc_ready1"}, 32'(req1_ready), 32'd0);
        checkOutput({tag, "_acc_rsp0"}, 32'(rsp0_valid), 32'd0);
        checkOutput({tag, "_acc_rsp1"}, 32'(rsp1_valid), 32'd0);
        @(posedge clock); #1;
        @(negedge clock);
        rspOwn   = v.expOwner ? rsp1_valid : rsp0_valid;
        rspOther = v.expOwner ? rsp0_valid : rsp1_valid;
        rdOwn    = v.expOwner ? rsp1_rdata : rsp0_rdata;
        perrOwn  = v.expOwner ? rsp1_perr  : rsp0_perr;
        checkOutput({tag, "_rsp_own_valid"}, 32'(rspOwn), 32'd1);
        checkOutput({tag, "_rsp_other_valid"}, 32'(rspOther), 32'd0);
        checkOutput({tag, "_rsp_rdata"}, 32'(rdOwn), 32'(v.expRdata));
        checkOutput({tag, "_rsp_perr"}, 32'(perrOwn), 32'(v.expPerr));
        checkOutput({tag, "_rsp_ready0"}, 32'(req0_ready), 32'd0);
        checkOutput({tag, "_rsp_ready1"}, 32'(req1_ready), 32'd0);
        @(posedge clock); #1;
    endtask

    initial begin
        //           v0    w0    a0     d0    v1    w1    a1     d1    own   rd    perr
        vecs[0]  = '{1'b1, 1'b1, 4'd3,  1'b1, 1'b1, 1'b0, 4'd3,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 4'd3,  1'b1, 1'b1, 1'b0, 4'd3,  1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 4'd5,  1'b0, 1'b1, 1'b1, 4'd5,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 4'd5,  1'b0, 1'b1, 1'b1, 4'd5,  1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 4'd5,  1'b0, 1'b1, 1'b0, 4'd3,  1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 4'd5,  1'b0, 1'b1, 1'b0, 4'd3,  1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 4'd15, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 4'd15, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 4'd3,  1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 4'd15, 1'b0, 1'b1, 1'b1, 1'b0};

        reset_n = 1'b0;
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = 4'd0; req0_wdata = 1'b0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = 4'd0; req1_wdata = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checkAllZero("reset");
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Reset asserted while an op sits in ACCESS: outputs clear, no response follows.
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 4'd7; req0_wdata = 1'b1;
        @(negedge clock);
        checkOutput("midrst_ready0", 32'(req0_ready), 32'd1);
        @(posedge clock); #1;
        reset_n = 1'b0;
        req0_valid = 1'b0;
        #1;
        checkAllZero("midrst");
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            checkOutput($sformatf("midrst_norsp0_c%0d", i), 32'(rsp0_valid), 32'd0);
            checkOutput($sformatf("midrst_norsp1_c%0d", i), 32'(rsp1_valid), 32'd0);
        end
        @(posedge clock); #1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i], i);
        end

`ifdef RAM_ARBITER_PARITY_EN
        begin
            vec_t pv;
            pv = '{1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
            applyStimulus(pv, 100);
            dut.u_bank.mem_q[2][0] = ~dut.u_bank.mem_q[2][0];
            pv = '{1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
            applyStimulus(pv, 101);
        end
`endif

        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_ram_arbiter
